// File: rtl/rv_exit_monitor_if.sv
// Retire-stream and status bundle between an rv32 core (master) and its exit monitor (slave).
interface rv_exit_monitor_if #(
  parameter int CNT_W   = 32,
  parameter int ECALL_W = 16
);
  logic               ir_valid;
  logic [31:0]        ir;
  logic [31:0]        sysno;
  logic [31:0]        arg0;
  logic [CNT_W-1:0]   timeout_limit;
  logic               clr;

  logic               running;
  logic               done;
  logic               finish_req;
  logic               timed_out;
  logic [31:0]        exit_code;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   instret;
  logic [ECALL_W-1:0] ecall_cnt;

  modport master (
    output ir_valid, ir, sysno, arg0, timeout_limit, clr,
    input  running, done, finish_req, timed_out, exit_code, cycle_cnt, instret, ecall_cnt
  );

  modport slave (
    input  ir_valid, ir, sysno, arg0, timeout_limit, clr,
    output running, done, finish_req, timed_out, exit_code, cycle_cnt, instret, ecall_cnt
  );
endinterface

// File: rtl/rv_exit_monitor.sv
// Program-termination monitor: detects the exit ecall or a cycle timeout, keeps
// saturating run statistics and raises a one-cycle finish_req after a drain delay.
module rv_exit_monitor #(
  parameter int SYS_EXIT     = 93,
  parameter int DRAIN_CYCLES = 5,
  parameter int CNT_W        = 32,
  parameter int ECALL_W      = 16
) (
  input  logic cclk,
  input  logic xreset,
  rv_exit_monitor_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [7:0]         drain_reg, drain_next;
  logic [CNT_W-1:0]   cycle_cnt_reg, cycle_cnt_next;
  logic [CNT_W-1:0]   instret_reg, instret_next;
  logic [ECALL_W-1:0] ecall_cnt_reg, ecall_cnt_next;
  logic               timed_out_reg, timed_out_next;
  logic [31:0]        exit_code_reg, exit_code_next;
  logic               finish_req_reg, finish_req_next;
  logic               running, done;

  logic             is_ecall, is_exit, is_timeout;
  logic [CNT_W-1:0] cycle_inc;

  assign is_ecall   = bus.ir_valid && (bus.ir == 32'h0000_0073);
  assign is_exit    = is_ecall && (bus.sysno == 32'(SYS_EXIT));
  // Wraps to zero once saturated, so a non-zero limit can never match past all-ones.
  assign cycle_inc  = cycle_cnt_reg + CNT_W'(1);
  assign is_timeout = (bus.timeout_limit != '0) && (cycle_inc == bus.timeout_limit);

  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset) begin
      state_reg      <= RUN;
      drain_reg      <= '0;
      cycle_cnt_reg  <= '0;
      instret_reg    <= '0;
      ecall_cnt_reg  <= '0;
      timed_out_reg  <= 1'b0;
      exit_code_reg  <= '0;
      finish_req_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      drain_reg      <= drain_next;
      cycle_cnt_reg  <= cycle_cnt_next;
      instret_reg    <= instret_next;
      ecall_cnt_reg  <= ecall_cnt_next;
      timed_out_reg  <= timed_out_next;
      exit_code_reg  <= exit_code_next;
      finish_req_reg <= finish_req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.clr) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (is_exit || is_timeout) state_next = DRAIN;
        DRAIN:   if (drain_reg == 8'd0)     state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    drain_next      = drain_reg;
    cycle_cnt_next  = cycle_cnt_reg;
    instret_next    = instret_reg;
    ecall_cnt_next  = ecall_cnt_reg;
    timed_out_next  = timed_out_reg;
    exit_code_next  = exit_code_reg;
    finish_req_next = 1'b0;
    if (bus.clr) begin
      drain_next     = '0;
      cycle_cnt_next = '0;
      instret_next   = '0;
      ecall_cnt_next = '0;
      timed_out_next = 1'b0;
      exit_code_next = '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (!(&cycle_cnt_reg))                 cycle_cnt_next = cycle_inc;
          if (bus.ir_valid && !(&instret_reg))   instret_next   = instret_reg + CNT_W'(1);
          if (is_ecall && !(&ecall_cnt_reg))     ecall_cnt_next = ecall_cnt_reg + ECALL_W'(1);
          // A real exit in the same cycle as the timeout takes precedence.
          if (is_exit) begin
            exit_code_next = bus.arg0;
            timed_out_next = 1'b0;
            drain_next     = 8'(DRAIN_CYCLES);
          end else if (is_timeout) begin
            exit_code_next = 32'hFFFF_FFFF;
            timed_out_next = 1'b1;
            drain_next     = 8'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (drain_reg == 8'd0) finish_req_next = 1'b1;
          else                   drain_next      = drain_reg - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    running = (state_reg == RUN);
    done    = (state_reg == DONE);
  end

  assign bus.running    = running;
  assign bus.done       = done;
  assign bus.finish_req = finish_req_reg;
  assign bus.timed_out  = timed_out_reg;
  assign bus.exit_code  = exit_code_reg;
  assign bus.cycle_cnt  = cycle_cnt_reg;
  assign bus.instret    = instret_reg;
  assign bus.ecall_cnt  = ecall_cnt_reg;
endmodule

// File: tb/tb_rv_exit_monitor.sv
// Randomised bench for rv_exit_monitor against an event-level model (32-bit and 16-bit counter builds).
module tb_rv_exit_monitor;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] CSRR  = 32'h3000_2573;
  localparam int          DRAIN = 5;

  logic cclk = 1'b0;
  logic xreset = 1'b0;
  logic rst_sat_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   sat_edges = 0;

  always #5 cclk = ~cclk;

  rv_exit_monitor_if #(.CNT_W(32), .ECALL_W(16)) bus0 ();
  rv_exit_monitor_if #(.CNT_W(16), .ECALL_W(16)) bus1 ();

  rv_exit_monitor #(.SYS_EXIT(93), .DRAIN_CYCLES(DRAIN), .CNT_W(32), .ECALL_W(16))
    dut (.cclk(cclk), .xreset(xreset), .bus(bus0));
  rv_exit_monitor #(.SYS_EXIT(93), .DRAIN_CYCLES(DRAIN), .CNT_W(16), .ECALL_W(16))
    dut_sat (.cclk(cclk), .xreset(rst_sat_n), .bus(bus1));

  // Model: a run is "terminated" at some edge; everything afterwards is edges-since-termination.
  longint      m_cyc[2], m_ins[2], m_ecl[2];
  bit          m_term[2], m_to[2];
  int          m_since[2];
  logic [31:0] m_code[2];

  function automatic void m_reset(int k);
    m_cyc[k] = 0; m_ins[k] = 0; m_ecl[k] = 0;
    m_term[k] = 0; m_to[k] = 0; m_since[k] = 0; m_code[k] = 32'h0;
  endfunction

  function automatic longint sat_inc(longint v, longint vmax);
    return (v >= vmax) ? vmax : v + 1;
  endfunction

  function automatic void m_step(int k, bit v, logic [31:0] ir_w, logic [31:0] sys,
                                 logic [31:0] a0, longint lim, bit c, longint cmax);
    bit ec, ex, tmo;
    if (c) begin
      m_reset(k);
    end else if (!m_term[k]) begin
      ec  = v && (ir_w == ECALL);
      ex  = ec && (sys == 32'd93);
      tmo = (lim != 0) && (((m_cyc[k] + 1) & cmax) == lim);
      m_cyc[k] = sat_inc(m_cyc[k], cmax);
      if (v)  m_ins[k] = sat_inc(m_ins[k], cmax);
      if (ec) m_ecl[k] = sat_inc(m_ecl[k], 64'hFFFF);
      if (ex) begin
        m_term[k] = 1; m_to[k] = 0; m_code[k] = a0; m_since[k] = 0;
      end else if (tmo) begin
        m_term[k] = 1; m_to[k] = 1; m_code[k] = 32'hFFFF_FFFF; m_since[k] = 0;
      end
    end else if (m_since[k] < 1000) begin
      m_since[k]++;
    end
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int k, logic run, logic dn, logic fin, logic to, logic [31:0] code,
                     logic [63:0] cyc, logic [63:0] ins, logic [63:0] ecl);
    string p;
    p = (k == 0) ? "dut" : "sat";
    check({p, ".running"},    64'(run),  64'(!m_term[k]));
    check({p, ".done"},       64'(dn),   64'(m_term[k] && m_since[k] >= DRAIN + 1));
    check({p, ".finish_req"}, 64'(fin),  64'(m_term[k] && m_since[k] == DRAIN + 1));
    check({p, ".timed_out"},  64'(to),   64'(m_to[k]));
    check({p, ".exit_code"},  64'(code), 64'(m_code[k]));
    check({p, ".cycle_cnt"},  cyc,       m_cyc[k]);
    check({p, ".instret"},    ins,       m_ins[k]);
    check({p, ".ecall_cnt"},  ecl,       m_ecl[k]);
  endtask

  // Continuous model comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge cclk);
      cmp(0, bus0.running, bus0.done, bus0.finish_req, bus0.timed_out, bus0.exit_code,
          64'(bus0.cycle_cnt), 64'(bus0.instret), 64'(bus0.ecall_cnt));
      cmp(1, bus1.running, bus1.done, bus1.finish_req, bus1.timed_out, bus1.exit_code,
          64'(bus1.cycle_cnt), 64'(bus1.instret), 64'(bus1.ecall_cnt));
    end
  end

  task automatic tick();
    @(posedge cclk);
    if (!xreset) m_reset(0);
    else m_step(0, bus0.ir_valid, bus0.ir, bus0.sysno, bus0.arg0,
                longint'(bus0.timeout_limit), bus0.clr, 64'hFFFF_FFFF);
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] ir_w, logic [31:0] sys, logic [31:0] a0);
    bus0.ir_valid = v; bus0.ir = ir_w; bus0.sysno = sys; bus0.arg0 = a0;
  endtask

  task automatic do_clr();
    bus0.clr = 1'b1; drive(1'b1, ECALL, 32'd93, 32'h55); tick(); bus0.clr = 1'b0;
  endtask

  task automatic wait_done(int budget, output int n);
    n = 0;
    while (!bus0.done && n < budget) begin tick(); n++; end
    if (!bus0.done) check("done_timeout", 64'(bus0.done), 64'd1);
  endtask

  // Free-running 16-bit instance, used for saturation; never terminated or cleared.
  initial begin
    bus1.ir_valid = 0; bus1.ir = NOP; bus1.sysno = 0; bus1.arg0 = 0;
    bus1.timeout_limit = '0; bus1.clr = 1'b0;
    m_reset(1);
    wait (rst_sat_n);
    forever begin
      bus1.ir_valid = ($urandom_range(0, 99) != 0);
      bus1.ir       = ($urandom_range(0, 19) == 0) ? ECALL : NOP;
      bus1.sysno    = ($urandom_range(0, 1) == 0) ? 32'd64 : 32'd17;
      bus1.arg0     = $urandom;
      @(posedge cclk);
      m_step(1, bus1.ir_valid, bus1.ir, bus1.sysno, bus1.arg0, 0, 1'b0, 64'hFFFF);
      sat_edges++;
      #1;
    end
  end

  initial begin
    int n, lim, cnt;
    logic [31:0] ir_w, sys;
    bus0.clr = 1'b0; bus0.timeout_limit = '0;
    drive(1'b0, NOP, 32'd0, 32'd0);
    m_reset(0);
    repeat (3) tick();
    #1;
    check("reset.running", 64'(bus0.running), 64'd1);
    check("reset.exit_code", 64'(bus0.exit_code), 64'd0);
    xreset = 1'b1; rst_sat_n = 1'b1;

    // Exit on the 100th edge after reset release.
    drive(1'b1, NOP, 32'd0, 32'd0);
    repeat (99) tick();
    drive(1'b1, ECALL, 32'd93, 32'd0);
    tick();
    drive(1'b0, NOP, 32'd0, 32'd0);
    check("t1.running", 64'(bus0.running), 64'd0);
    check("t1.cycle_cnt", 64'(bus0.cycle_cnt), 64'd100);
    check("t1.instret", 64'(bus0.instret), 64'd100);
    check("t1.ecall_cnt", 64'(bus0.ecall_cnt), 64'd1);
    wait_done(20, n);
    check("t1.done_latency", 64'(n), 64'd6);
    check("t1.finish_rise", 64'(bus0.finish_req), 64'd1);
    tick();
    check("t1.finish_fall", 64'(bus0.finish_req), 64'd0);
    check("t1.done_hold", 64'(bus0.done), 64'd1);
    $display("run exit100: code=%h cycles=%0d", bus0.exit_code, bus0.cycle_cnt);

    // Non-exit ecalls back-to-back, then exit with code 7.
    do_clr();
    check("clr.running", 64'(bus0.running), 64'd1);
    check("clr.cycle_cnt", 64'(bus0.cycle_cnt), 64'd0);
    drive(1'b1, NOP, 32'd0, 32'd0);
    repeat (5) tick();
    drive(1'b1, ECALL, 32'd64, 32'd1);
    repeat (3) tick();
    drive(1'b1, ECALL, 32'd93, 32'd7);
    tick();
    drive(1'b0, NOP, 32'd0, 32'd0);
    check("t2.ecall_cnt", 64'(bus0.ecall_cnt), 64'd4);
    check("t2.exit_code", 64'(bus0.exit_code), 64'd7);
    check("t2.timed_out", 64'(bus0.timed_out), 64'd0);
    check("t2.cycle_cnt", 64'(bus0.cycle_cnt), 64'd9);
    wait_done(20, n);
    $display("run syscalls: code=%h ecalls=%0d", bus0.exit_code, bus0.ecall_cnt);

    // Timeout at 50 with non-ecall SYSTEM traffic.
    bus0.timeout_limit = 32'd50;
    do_clr();
    for (int i = 0; i < 49; i++) begin
      cnt = $urandom_range(0, 2);
      drive($urandom_range(0, 1) == 1, (cnt == 0) ? EBRK : (cnt == 1) ? CSRR : NOP, 32'd93, 32'd3);
      tick();
    end
    drive(1'b0, NOP, 32'd0, 32'd0);
    check("t3.pre_running", 64'(bus0.running), 64'd1);
    tick();
    check("t3.running", 64'(bus0.running), 64'd0);
    check("t3.cycle_cnt", 64'(bus0.cycle_cnt), 64'd50);
    check("t3.timed_out", 64'(bus0.timed_out), 64'd1);
    check("t3.exit_code", 64'(bus0.exit_code), 64'hFFFF_FFFF);
    wait_done(20, n);
    check("t3.done_latency", 64'(n), 64'd6);
    $display("run timeout: code=%h cycles=%0d", bus0.exit_code, bus0.cycle_cnt);

    // Exit and timeout on the same edge: exit wins.
    do_clr();
    drive(1'b1, NOP, 32'd0, 32'd0);
    repeat (49) tick();
    drive(1'b1, ECALL, 32'd93, 32'h1234);
    tick();
    check("t3b.timed_out", 64'(bus0.timed_out), 64'd0);
    check("t3b.exit_code", 64'(bus0.exit_code), 64'h1234);
    check("t3b.cycle_cnt", 64'(bus0.cycle_cnt), 64'd50);

    // Retire traffic through DRAIN and DONE must not move anything.
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? ECALL : NOP,
            32'd93, $urandom);
      tick();
    end
    check("t4.done", 64'(bus0.done), 64'd1);
    check("t4.cycle_cnt", 64'(bus0.cycle_cnt), 64'd50);
    check("t4.instret", 64'(bus0.instret), 64'd50);
    check("t4.ecall_cnt", 64'(bus0.ecall_cnt), 64'd1);
    check("t4.exit_code", 64'(bus0.exit_code), 64'h1234);
    $display("run frozen: code=%h cycles=%0d", bus0.exit_code, bus0.cycle_cnt);
    bus0.timeout_limit = '0;
    do_clr();
    check("t4.clr_running", 64'(bus0.running), 64'd1);
    check("t4.clr_done", 64'(bus0.done), 64'd0);
    check("t4.clr_instret", 64'(bus0.instret), 64'd0);
    check("t4.clr_ecall", 64'(bus0.ecall_cnt), 64'd0);
    drive(1'b1, NOP, 32'd0, 32'd0);
    repeat (10) tick();
    check("t4.recount", 64'(bus0.instret), 64'd10);

    // Asynchronous reset mid-DRAIN, asserted between edges.
    drive(1'b1, ECALL, 32'd93, 32'd9);
    tick();
    drive(1'b0, NOP, 32'd0, 32'd0);
    repeat (2) tick();
    #2 xreset = 1'b0;
    #1;
    check("t5.running", 64'(bus0.running), 64'd1);
    check("t5.finish_req", 64'(bus0.finish_req), 64'd0);
    check("t5.exit_code", 64'(bus0.exit_code), 64'd0);
    check("t5.cycle_cnt", 64'(bus0.cycle_cnt), 64'd0);
    m_reset(0);
    repeat (8) tick();
    xreset = 1'b1;
    drive(1'b1, NOP, 32'd0, 32'd0);
    repeat (3) tick();
    check("t5.restart", 64'(bus0.cycle_cnt), 64'd3);
    $display("run async_reset: cycles=%0d", bus0.cycle_cnt);

    // Randomised programs.
    for (int r = 0; r < 24; r++) begin
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 150);
      bus0.timeout_limit = 32'(lim);
      do_clr();
      cnt = 0;
      for (int i = 0; i < 400 && cnt < 4; i++) begin
        n = $urandom_range(0, 9);
        ir_w = (n == 0) ? ECALL : (n == 1) ? EBRK : (n == 2) ? CSRR : $urandom;
        if (ir_w == ECALL && n != 0) ir_w = NOP;
        sys = ($urandom_range(0, 7) == 0) ? 32'd93 : 32'd64;
        drive($urandom_range(0, 3) != 0, ir_w, sys, $urandom);
        bus0.clr = ($urandom_range(0, 299) == 0);
        tick();
        bus0.clr = 1'b0;
        if (bus0.done) cnt++;
      end
      $display("run random %0d: limit=%0d code=%h timed_out=%0d cycles=%0d",
               r, lim, bus0.exit_code, bus0.timed_out, bus0.cycle_cnt);
    end
    drive(1'b0, NOP, 32'd0, 32'd0);
    bus0.timeout_limit = '0;

    while (sat_edges < 70000) tick();
    check("sat.cycle_cnt", 64'(bus1.cycle_cnt), 64'hFFFF);
    check("sat.running", 64'(bus1.running), 64'd1);
    $display("run saturate: edges=%0d cycles=%h instret=%h", sat_edges, bus1.cycle_cnt, bus1.instret);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
